// File: rtl/mux_4by1_using_2by1_mux.sv
// mux_4by1_using_2by1_mux
//   Lane selector that picks one of four DATA_W-bit lanes. It is built as a
//   two-level tree of three 2:1 cells: two cells on s[0], then one cell on
//   s[1]. It has a combinational output and an optional registered copy.
//
// Ports
//   y      out  DATA_W    combinational selected lane (s=k -> lane k)
//   s      in   2         lane select
//   i      in   4*DATA_W  packed lanes, lane k = i[k*DATA_W +: DATA_W]
//   clk    in   1         rising-edge clock, registered stage only
//   rst    in   1         async active-high reset, registered stage only
//   en     in   1         capture enable for y_q
//   y_q    out  DATA_W    registered copy of y
//   y_vld  out  1         y_q was loaded on the last rising edge
//   err    out  1         (only with MUX_CHK_EN) sticky tree-vs-flat mismatch
//
// Build option
//   MUX_CHK_EN : adds the err port and a flat lane[s] selector. The flat
//                selector is checked against the tree on each rising edge.

module mux_2by1_cell #(
  parameter int DATA_W = 1
) (
  input  logic              sel_i,
  input  logic [DATA_W-1:0] in0_i,
  input  logic [DATA_W-1:0] in1_i,
  output logic [DATA_W-1:0] out_o
);
  assign out_o = sel_i ? in1_i : in0_i;
endmodule

module mux_4by1_using_2by1_mux #(
  parameter int DATA_W = 1
) (
  output logic [DATA_W-1:0]   y,
  input  logic [1:0]          s,
  input  logic [4*DATA_W-1:0] i,
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic [DATA_W-1:0]   y_q,
`ifdef MUX_CHK_EN
  output logic                y_vld,
  output logic                err
`else
  output logic                y_vld
`endif
);

  logic [3:0][DATA_W-1:0] lane;
  logic [DATA_W-1:0]      m0, m1;

  assign lane = i;

  // Level 1: the same select bit pairs lanes {0,1} and {2,3}.
  mux_2by1_cell #(.DATA_W(DATA_W)) u_l1_lo (
    .sel_i(s[0]), .in0_i(lane[0]), .in1_i(lane[1]), .out_o(m0)
  );
  mux_2by1_cell #(.DATA_W(DATA_W)) u_l1_hi (
    .sel_i(s[0]), .in0_i(lane[2]), .in1_i(lane[3]), .out_o(m1)
  );

  // Level 2: s[1] chooses between the two pairs.
  mux_2by1_cell #(.DATA_W(DATA_W)) u_l2 (
    .sel_i(s[1]), .in0_i(m0), .in1_i(m1), .out_o(y)
  );

  // Registered stage. Data holds when en=0. The valid flag drops for that cycle.
  logic [DATA_W-1:0] data_q, data_d;
  logic              vld_q, vld_d;

  assign data_d = en ? y : data_q;
  assign vld_d  = en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign y_q   = data_q;
  assign y_vld = vld_q;

`ifdef MUX_CHK_EN
  // The flat selector is deliberately not built from the cells. A fault in
  // the tree wiring then shows up as a disagreement.
  logic [DATA_W-1:0] flat_sel;
  logic              err_q, err_d;

  assign flat_sel = lane[s];
  assign err_d    = err_q | (flat_sel != y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_mux_4by1_using_2by1_mux.sv
module tb_mux_4by1_using_2by1_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DATA_W=1 instance
  logic [1:0] s1 = '0;
  logic [3:0] i1 = '0;
  logic       en1 = 1'b0;
  logic       y1, yq1, vld1;

  // DATA_W=8 instance
  logic [1:0]  s8 = '0;
  logic [31:0] i8 = '0;
  logic        en8 = 1'b0;
  logic [7:0]  y8, yq8;
  logic        vld8;

`ifdef MUX_CHK_EN
  logic err1, err8;
`endif

  mux_4by1_using_2by1_mux #(.DATA_W(1)) dut1 (
    .y(y1), .s(s1), .i(i1), .clk(clk), .rst(rst), .en(en1),
`ifdef MUX_CHK_EN
    .y_q(yq1), .y_vld(vld1), .err(err1)
`else
    .y_q(yq1), .y_vld(vld1)
`endif
  );

  mux_4by1_using_2by1_mux #(.DATA_W(8)) dut8 (
    .y(y8), .s(s8), .i(i8), .clk(clk), .rst(rst), .en(en8),
`ifdef MUX_CHK_EN
    .y_q(yq8), .y_vld(vld8), .err(err8)
`else
    .y_q(yq8), .y_vld(vld8)
`endif
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
  endtask

  // Reference model: lane k is the k-th DATA_W-wide slice, found by shifting.
  function automatic logic [31:0] ref_sel(input int w, input logic [1:0] s, input logic [31:0] i);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 1);
    return (i >> (w * int'(s))) & mask;
  endfunction

  // Scoreboard for the DATA_W=8 registered stage.
  typedef struct { logic vld; logic [7:0] data; } exp_t;
  exp_t        sb[$];
  logic [7:0]  mdl_q = '0;

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.vld) mdl_q = e.data;
      chk("y_vld8", {31'b0, vld8}, {31'b0, e.vld});
      chk("y_q8", {24'b0, yq8}, {24'b0, mdl_q});
    end
  end

  initial begin
    logic [1:0] ts [10];
    logic [3:0] ti [10];
    ts = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
    ti = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b1101,
           4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0111};

    // Reset state is applied at once, with no clock edge.
    #1;
    chk("rst_yq1", {31'b0, yq1}, 32'd0);
    chk("rst_vld1", {31'b0, vld1}, 32'd0);
    chk("rst_yq8", {24'b0, yq8}, 32'd0);

    // Directed routing table. y is checked while rst is high, which also
    // shows that y does not depend on rst.
    for (int k = 0; k < 10; k++) begin
      s1 = ts[k]; i1 = ti[k]; #1;
      chk($sformatf("dir_s%0d_i%0h", ts[k], ti[k]), {31'b0, y1}, ref_sel(1, ts[k], {28'b0, ti[k]}));
    end

    // Exhaustive sweep over s and i.
    for (int sv = 0; sv < 4; sv++)
      for (int iv = 0; iv < 16; iv++) begin
        s1 = 2'(sv); i1 = 4'(iv); #1;
        chk("sweep", {31'b0, y1}, ref_sel(1, 2'(sv), 32'(iv)));
      end

    // Registered stage on the DATA_W=1 instance.
    @(negedge clk);
    rst = 1'b0; en1 = 1'b1; s1 = 2'd3; i1 = 4'b1000;
    @(posedge clk); #1;
    chk("load_yq1", {31'b0, yq1}, 32'd1);
    chk("load_vld1", {31'b0, vld1}, 32'd1);
    @(negedge clk);
    en1 = 1'b0; i1 = 4'b0000;
    @(posedge clk); #1;
    chk("hold_yq1", {31'b0, yq1}, 32'd1);
    chk("hold_vld1", {31'b0, vld1}, 32'd0);
    #2 rst = 1'b1; #1;
    chk("async_yq1", {31'b0, yq1}, 32'd0);
    chk("async_vld1", {31'b0, vld1}, 32'd0);

    // DATA_W=8: first the directed lanes, then random traffic through the scoreboard.
    @(negedge clk);
    rst = 1'b0; mdl_q = '0;
    i8 = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s8 = 2'(k); en8 = 1'b1; #1;
      chk("w8_y", {24'b0, y8}, ref_sel(8, s8, i8));
      sb.push_back('{vld: 1'b1, data: ref_sel(8, s8, i8)});
    end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      s8 = 2'($urandom_range(0, 3));
      i8 = $urandom;
      en8 = 1'($urandom_range(0, 1));
      #1;
      chk("rnd_y", {24'b0, y8}, ref_sel(8, s8, i8));
      sb.push_back('{vld: en8, data: ref_sel(8, s8, i8)});
    end
    @(negedge clk); en8 = 1'b0;
    sb.push_back('{vld: 1'b0, data: 8'h00});

    // Mid-run reset on the DATA_W=8 instance.
    @(posedge clk); #3;
    rst = 1'b1; #1;
    chk("async_yq8", {24'b0, yq8}, 32'd0);
    chk("async_vld8", {31'b0, vld8}, 32'd0);
    sb.delete(); mdl_q = '0;
    @(negedge clk); rst = 1'b0;

    // After release, the first edge with en=1 reloads the register.
    @(negedge clk);
    en8 = 1'b1; s8 = 2'd2; i8 = 32'h1122_3344; #1;
    sb.push_back('{vld: 1'b1, data: ref_sel(8, s8, i8)});
    @(negedge clk); en8 = 1'b0;
    sb.push_back('{vld: 1'b0, data: 8'h00});
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

`ifdef MUX_CHK_EN
    chk("err1", {31'b0, err1}, 32'd0);
    chk("err8", {31'b0, err8}, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
